bwt_seq_ctrl: RTL and testbench

Phase sequencer and memory-port owner for the BWT engine. On `start` it scans the single-port string RAM for the `$` terminator (8'd36) to obtain the string length. It then hands the RAM to the sort engine and afterwards to the emit engine through go/done handshakes. It multiplexes the RAM port to exactly one owner per phase and reports completion or error to the host.

---
 rtl/bwt_seq_ctrl_if.sv | 21 ++
 rtl/bwt_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_bwt_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bwt_seq_ctrl_if.sv
// bwt_seq_ctrl_if: single-port string RAM bus.
// The sequencer is master; the RAM is slave.
interface bwt_seq_ctrl_if #(
   parameter int len_addr = 10
) ();
   logic [len_addr-1:0] addr;
   logic                ren;
   logic                wen;
   logic [7:0]          dout;
   logic [7:0]          din;

   modport master (
      output addr, ren, wen, dout,
      input  din
   );

   modport slave (
      input  addr, ren, wen, dout,
      output din
   );
endinterface

// File: rtl/bwt_seq_ctrl.sv
// bwt_seq_ctrl: BWT phase sequencer and string RAM owner.
// Macro BWT_SCAN_TIMEOUT_EN: missing terminator ends the run in ERR.
module bwt_seq_ctrl #(
   parameter int len_addr    = 10,
   parameter int len_str_max = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [len_addr:0]   len_str,
   bwt_seq_ctrl_if.master      ram,
   output logic                sort_go,
   input  logic                sort_done,
   input  logic [len_addr-1:0] sort_addr,
   input  logic                sort_ren,
   input  logic                sort_wen,
   input  logic [7:0]          sort_wdata,
   output logic                emit_go,
   input  logic                emit_done,
   input  logic [len_addr-1:0] emit_addr,
   input  logic                emit_ren
);

   typedef enum logic [2:0] {
      IDLE, SCAN, SORT, EMIT, DONE_ST, ERR
   } state_t;

   localparam logic [len_addr:0] full =
      (len_addr+1)'(len_str_max);
   localparam logic [7:0] term = 8'd36;

   state_t          state;
   logic [len_addr:0] cnt;
   logic            hit;
   logic            at_end;

   // din carries the byte for cnt-1, so cnt==0 has nothing to test
   assign hit    = (cnt != '0) && (ram.din == term);
   assign at_end = (cnt == full);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         len_str <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         sort_go <= 1'b0;
         emit_go <= 1'b0;
      end else begin
         sort_go <= 1'b0;
         emit_go <= 1'b0;
         done    <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b0;
         end else begin
            unique case (state)
               IDLE, DONE_ST, ERR: begin
                  if (start) begin
                     state   <= SCAN;
                     busy    <= 1'b1;
                     err     <= 1'b0;
                     cnt     <= '0;
                     len_str <= '0;
                  end else if (state == DONE_ST) begin
                     state <= IDLE;
                  end
               end
               SCAN: begin
                  if (hit) begin
                     len_str <= cnt;
                     state   <= SORT;
                     sort_go <= 1'b1;
                  end else if (at_end) begin
`ifdef BWT_SCAN_TIMEOUT_EN
                     state <= ERR;
                     busy  <= 1'b0;
                     err   <= 1'b1;
`else
                     len_str <= cnt;
                     state   <= SORT;
                     sort_go <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SORT: begin
                  if (sort_done) begin
                     state   <= EMIT;
                     emit_go <= 1'b1;
                  end
               end
               EMIT: begin
                  if (emit_done) begin
                     state <= DONE_ST;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      ram.addr = '0;
      ram.ren  = 1'b0;
      ram.wen  = 1'b0;
      ram.dout = '0;
      unique case (state)
         SCAN: begin
            // last-address compare cycle holds the address, no wrap
            ram.addr = at_end ? '1 : cnt[len_addr-1:0];
            ram.ren  = !at_end;
         end
         SORT: begin
            ram.addr = sort_addr;
            ram.ren  = sort_ren;
            ram.wen  = sort_wen;
            ram.dout = sort_wdata;
         end
         EMIT: begin
            ram.addr = emit_addr;
            ram.ren  = emit_ren;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_bwt_seq_ctrl.sv
// tb_bwt_seq_ctrl: timeline model of a run checked every cycle.
// Randomized strings, engine latencies, aborts and a mid-scan reset.
module tb_bwt_seq_ctrl;
   localparam int LA    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, err, sort_go, emit_go;
   logic [LA:0]   len_str;
   logic          sort_done = 1'b0;
   logic          sort_ren = 1'b0;
   logic          sort_wen = 1'b0;
   logic [LA-1:0] sort_addr = '0;
   logic [7:0]    sort_wdata = '0;
   logic          emit_done = 1'b0;
   logic          emit_ren = 1'b0;
   logic [LA-1:0] emit_addr = '0;
   logic [7:0]    mem [DEPTH];

   int n_chk = 0;
   int n_fail = 0;
   int cur_j = -1;
   int sg_j = -1;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   bit e_busy, e_done, e_err, e_sgo, e_ego, e_ren, e_wen;
   int e_addr, e_dout, e_len;
   int m_len = 0;
   bit m_err = 1'b0;

   bwt_seq_ctrl_if #(.len_addr(LA)) ram ();

   bwt_seq_ctrl #(.len_addr(LA), .len_str_max(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err), .len_str(len_str),
      .ram(ram),
      .sort_go(sort_go), .sort_done(sort_done),
      .sort_addr(sort_addr), .sort_ren(sort_ren),
      .sort_wen(sort_wen), .sort_wdata(sort_wdata),
      .emit_go(emit_go), .emit_done(emit_done),
      .emit_addr(emit_addr), .emit_ren(emit_ren)
   );

   always #10 clk = ~clk;

   always @(posedge clk) if (ram.ren) ram.din <= mem[ram.addr];

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s j=%0d actual=%0d required=%0d",
                  nm, cur_j, a, e);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("sort_go", 32'(sort_go), 32'(e_sgo));
      chk("emit_go", 32'(emit_go), 32'(e_ego));
      chk("len_str", 32'(len_str), 32'(e_len));
      chk("addr", 32'(ram.addr), 32'(e_addr));
      chk("ren", 32'(ram.ren), 32'(e_ren));
      chk("wen", 32'(ram.wen), 32'(e_wen));
      chk("dout", 32'(ram.dout), 32'(e_dout));
      if (sort_go) sg_j = cur_j;
      if (done) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic void idle_exp();
      e_busy = 0; e_done = 0; e_err = m_err;
      e_sgo = 0; e_ego = 0; e_ren = 0; e_wen = 0;
      e_addr = 0; e_dout = 0; e_len = m_len;
   endfunction

   task automatic drive_rand();
      sort_addr  = LA'($urandom);
      sort_ren   = 1'($urandom);
      sort_wen   = 1'($urandom);
      sort_wdata = 8'($urandom);
      emit_addr  = LA'($urandom);
      emit_ren   = 1'($urandom);
      sort_done  = 1'($urandom);
      emit_done  = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         cur_j = -1;
         drive_rand();
         idle_exp();
      end
   endtask

   task automatic abort_now(input bit with_start);
      abort = 1'b1;
      start = with_start;
      step();
      abort = 1'b0;
      start = 1'b0;
      cur_j = -1;
      m_err = 1'b0;
      drive_rand();
      idle_exp();
   endtask

   // k<0: no terminator; ab_j/rs_j: interval of abort/reset, -1 none
   task automatic run(input int k, input int ds, input int de,
                      input int ab_j, input int rs_j);
      int kk, last, s_end, e_end;
      bit found, to_err;
      found = (k >= 0);
      kk = found ? k : DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (b == 8'd36) b = 8'd37;
         mem[i] = b;
      end
      if (found) begin
         mem[k] = 8'd36;
         if (k == 2) begin mem[0] = 8'd97; mem[1] = 8'd98; end
         if (k < DEPTH - 1 && $urandom_range(0, 1) == 1)
            mem[$urandom_range(k + 1, DEPTH - 1)] = 8'd36;
      end
      to_err = 1'b0;
`ifdef BWT_SCAN_TIMEOUT_EN
      to_err = !found;
`endif
      s_end = kk + 2 + ds;
      e_end = kk + 3 + ds + de;
      last = to_err ? kk + 2 : e_end + 1;
      start = 1'b1;
      step();
      start = 1'b0;
      m_err = 1'b0;
      m_len = 0;
      for (int j = 0; j <= last; j++) begin
         cur_j = j;
         drive_rand();
         if (!to_err && j >= kk + 2 && j <= s_end)
            sort_done = (j == s_end);
         if (!to_err && j > s_end && j <= e_end)
            emit_done = (j == e_end);
         idle_exp();
         if (j <= kk + 1) begin
            e_busy = 1; e_len = 0;
            e_addr = (j > DEPTH - 1) ? DEPTH - 1 : j;
            e_ren = (j <= DEPTH - 1);
         end else if (to_err) begin
            e_err = 1; e_len = 0;
         end else begin
            e_len = kk + 1;
            if (j <= s_end) begin
               e_busy = 1; e_sgo = (j == kk + 2);
               e_addr = int'(sort_addr); e_ren = sort_ren;
               e_wen = sort_wen; e_dout = int'(sort_wdata);
            end else if (j <= e_end) begin
               e_busy = 1; e_ego = (j == s_end + 1);
               e_addr = int'(emit_addr); e_ren = emit_ren;
            end else begin
               e_done = 1;
            end
         end
         if (j == rs_j) begin
            #2 reset = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ren", 32'(ram.ren), 0);
            chk("rst_addr", 32'(ram.addr), 0);
            chk("rst_len", 32'(len_str), 0);
            chk("rst_sgo", 32'(sort_go), 0);
            m_len = 0; m_err = 0; cur_j = -1;
            idle_exp();
            #1 reset = 1'b1;
            return;
         end
         if (j == ab_j) begin
            sort_done = 1'b1;
            m_len = e_len;
            abort_now(1'b0);
            return;
         end
         if (j == last) begin
            m_len = e_len;
            m_err = e_err;
            return;
         end
         step();
      end
   endtask

   initial begin
      int k, ds, de, ab, tot;
      idle_exp();
      step();
      chk_en = 1'b1;
      step();
      step();
      reset = 1'b1;
      idle(2);

      sg_j = -1;
      run(2, 5, 3, -1, -1);
      chk("ab_len", 32'(len_str), 3);
      chk("ab_sgo_at", 32'(sg_j), 4);
      idle(2);

      done_cnt = 0;
      run(0, 5, 3, -1, -1);
      idle(2);
      chk("z_len", 32'(len_str), 1);
      chk("z_done_cnt", 32'(done_cnt), 1);
      chk("z_busy", 32'(busy), 0);

      run(1023, 0, 0, -1, -1);
      chk("full_len", 32'(len_str), 1024);
      idle(1);

      sg_j = -1;
      run(-1, 1, 1, -1, -1);
      idle(2);
`ifdef BWT_SCAN_TIMEOUT_EN
      chk("none_err", 32'(err), 1);
      chk("none_len", 32'(len_str), 0);
      chk("none_sgo_at", 32'(sg_j), 32'hffffffff);
`else
      chk("none_err", 32'(err), 0);
      chk("none_len", 32'(len_str), 1024);
      chk("none_sgo_at", 32'(sg_j), 1025);
`endif
      abort_now(1'b1);
      idle(1);
      chk("abort_start_busy", 32'(busy), 0);

      done_cnt = 0;
      run(5, 4, 2, 9, -1);
      idle(3);
      chk("ab_sort_done_cnt", 32'(done_cnt), 0);
      chk("ab_sort_len", 32'(len_str), 6);

      run(300, 1, 1, -1, 100);
      idle(1);
      run(3, 0, 0, -1, -1);
      idle(1);

      for (int r = 0; r < 24; r++) begin
         k = ($urandom_range(0, 7) == 0) ? -1
                                         : $urandom_range(0, 1023);
         ds = $urandom_range(0, 6);
         de = $urandom_range(0, 6);
         tot = ((k < 0) ? 1023 : k) + 4 + ds + de;
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, tot) : -1;
         run(k, ds, de, ab, -1);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      end
      idle(2);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
